// File: rtl/uart_instruction_sequencer.sv
// uart_instruction_sequencer
// Buffers 15-bit instructions from the UART receiver in a small FIFO and
// dispatches them to the execution datapath over a valid/ack handshake.
// NOP instructions (opcode 0) are popped and discarded without dispatch.
// A command that is not acked within TIMEOUT_CYCLES is aborted.
// Dropped instructions and timeouts raise sticky error flags.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   instruction_in/_ready      instruction word and its one-cycle strobe
//   enable                     gate for starting new dispatches
//   clear_err                  strobe clearing overflow/timeout_err/drop_count
//   cmd_valid/opcode/operand   command presented to the datapath
//   cmd_ack                    datapath acceptance
//   fifo_level                 queued entries, excluding the in-flight command
//   overflow, timeout_err      sticky error flags
//   drop_count                 saturating count of dropped instructions
//   busy                       command in flight or queue not empty
//
// state | meaning
// IDLE  | no command in flight; may pop the FIFO head
// ISSUE | command presented, waiting for ack or timeout
module uart_instruction_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [14:0]              instruction_in,
    input  logic                     instruction_ready,
    input  logic                     enable,
    input  logic                     clear_err,
    output logic                     cmd_valid,
    output logic [2:0]               cmd_opcode,
    output logic [11:0]              cmd_operand,
    input  logic                     cmd_ack,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     timeout_err,
    output logic [7:0]               drop_count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    logic [14:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   tmo_cnt;

    logic [14:0]     head;
    logic            head_nop;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            tmo_hit;
    logic            tmo_event;
    logic            issue_next;
    logic [LW-1:0]   level_next;

    always_comb begin
        head       = mem[rd_ptr];
        head_nop   = (head[14:12] == 3'b000);
        full       = (fifo_level == LW'(DEPTH));
        pop        = (state == IDLE) && enable && (fifo_level != '0);
        // A full FIFO still accepts a word when the head leaves on the same edge.
        push       = instruction_ready && (!full || pop);
        drop       = instruction_ready && !push;
        // The counter holds the number of unacked edges already spent in ISSUE.
        tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        tmo_event  = (state == ISSUE) && !cmd_ack && tmo_hit;
        level_next = fifo_level + LW'(push) - LW'(pop);
        if (state == IDLE) begin
            issue_next = pop && !head_nop;
        end else begin
            issue_next = !(cmd_ack || tmo_hit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= instruction_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= '0;
            cmd_operand <= '0;
            tmo_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            drop_count  <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop && !head_nop) begin
                        state       <= ISSUE;
                        cmd_valid   <= 1'b1;
                        cmd_opcode  <= head[14:12];
                        cmd_operand <= head[11:0];
                        tmo_cnt     <= '0;
                    end
                end
                ISSUE: begin
                    // Ack takes priority over a coincident timeout.
                    if (cmd_ack || tmo_hit) begin
                        state     <= IDLE;
                        cmd_valid <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_level <= level_next;

            // A new error event on the same edge as clear_err wins.
            if (tmo_event) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (clear_err) begin
                    drop_count <= 8'd1;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (clear_err) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end

            busy <= issue_next || (level_next != '0);
        end
    end

endmodule

// File: tb/tb_uart_instruction_sequencer.sv
module tb_uart_instruction_sequencer;

    localparam int DEPTH = 4;
    localparam int TOUT  = 8;

    logic        clk;
    logic        reset;
    logic [14:0] instruction_in;
    logic        instruction_ready;
    logic        enable;
    logic        clear_err;
    logic        cmd_valid;
    logic [2:0]  cmd_opcode;
    logic [11:0] cmd_operand;
    logic        cmd_ack;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        timeout_err;
    logic [7:0]  drop_count;
    logic        busy;

    uart_instruction_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk),
        .reset(reset),
        .instruction_in(instruction_in),
        .instruction_ready(instruction_ready),
        .enable(enable),
        .clear_err(clear_err),
        .cmd_valid(cmd_valid),
        .cmd_opcode(cmd_opcode),
        .cmd_operand(cmd_operand),
        .cmd_ack(cmd_ack),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .timeout_err(timeout_err),
        .drop_count(drop_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the queue holds waiting words, the in-flight command
    // is tracked separately along with how many cycles it has been shown.
    logic [14:0] q[$];
    logic        m_valid;
    logic [2:0]  m_op;
    logic [11:0] m_opnd;
    int          m_high;
    logic        m_ovf;
    logic        m_tout;
    int          m_drops;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_op    = '0;
        m_opnd  = '0;
        m_high  = 0;
        m_ovf   = 1'b0;
        m_tout  = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_step();
        logic        do_pop, ack_ev, to_ev, do_push, do_drop;
        logic [14:0] w;
        do_pop  = !m_valid && enable && (q.size() > 0);
        ack_ev  = m_valid && cmd_ack;
        to_ev   = m_valid && !cmd_ack && (m_high == TOUT);
        do_push = instruction_ready && ((q.size() < DEPTH) || do_pop);
        do_drop = instruction_ready && !do_push;
        if (do_pop) begin
            w = q.pop_front();
            if (w[14:12] != 3'b000) begin
                m_valid = 1'b1;
                m_op    = w[14:12];
                m_opnd  = w[11:0];
                m_high  = 1;
            end
        end else if (ack_ev || to_ev) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_high++;
        end
        if (do_push) q.push_back(instruction_in);
        if (to_ev) m_tout = 1'b1;
        else if (clear_err) m_tout = 1'b0;
        if (do_drop) begin
            m_ovf   = 1'b1;
            m_drops = clear_err ? 1 : ((m_drops >= 255) ? 255 : m_drops + 1);
        end else if (clear_err) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
    endtask

    task automatic check_all();
        chk("cmd_valid",   32'(cmd_valid),   32'(m_valid));
        chk("cmd_opcode",  32'(cmd_opcode),  32'(m_op));
        chk("cmd_operand", 32'(cmd_operand), 32'(m_opnd));
        chk("fifo_level",  32'(fifo_level),  32'(q.size()));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("timeout_err", 32'(timeout_err), 32'(m_tout));
        chk("drop_count",  32'(drop_count),  32'(m_drops));
        chk("busy",        32'(busy),        32'(m_valid || (q.size() != 0)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic strobe(input logic [14:0] w);
        instruction_in    = w;
        instruction_ready = 1'b1;
        tick();
        instruction_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        cmd_ack = 1'b1;
        enable  = 1'b1;
        while ((m_valid || q.size() != 0) && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_bound", 32'(guard < 50), 32'd1);
    endtask

    initial begin
        int cnt;
        instruction_in    = '0;
        instruction_ready = 1'b0;
        enable            = 1'b1;
        clear_err         = 1'b0;
        cmd_ack           = 1'b0;
        reset             = 1'b1;
        model_reset();
        #1;
        do_reset();
        tick();

        // Single instruction with ack high: valid two cycles after the strobe.
        cmd_ack = 1'b1;
        strobe(15'h5ABC);
        chk("t1_level", 32'(fifo_level), 32'd1);
        chk("t1_valid_k1", 32'(cmd_valid), 32'd0);
        tick();
        chk("t1_valid_k2", 32'(cmd_valid), 32'd1);
        chk("t1_opcode", 32'(cmd_opcode), 32'd5);
        chk("t1_operand", 32'(cmd_operand), 32'hABC);
        tick();
        chk("t1_valid_drop", 32'(cmd_valid), 32'd0);
        chk("t1_level_end", 32'(fifo_level), 32'd0);

        // Six strobes against a stalled datapath: one in flight, four queued, one dropped.
        cmd_ack = 1'b0;
        for (int i = 0; i < 6; i++) strobe(15'(16'h1010 + 16'(i * 16'h1111)));
        chk("t2_level", 32'(fifo_level), 32'd4);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_drops", 32'(drop_count), 32'd1);
        drain();

        // Push on a full FIFO while the head pops: no drop.
        enable = 1'b0;
        cmd_ack = 1'b0;
        for (int i = 0; i < 4; i++) strobe(15'(16'h6100 + 16'(i)));
        chk("t3_full", 32'(fifo_level), 32'd4);
        enable = 1'b1;
        strobe(15'h6200);
        chk("t3_level_stays", 32'(fifo_level), 32'd4);
        chk("t3_no_new_drop", 32'(drop_count), 32'd1);
        drain();

        // NOP ahead of a real command delays it by one cycle.
        strobe(15'h0123);
        strobe(15'h7FFF);
        chk("t4_nop_no_valid", 32'(cmd_valid), 32'd0);
        tick();
        chk("t4_valid", 32'(cmd_valid), 32'd1);
        chk("t4_opcode", 32'(cmd_opcode), 32'd7);
        chk("t4_operand", 32'(cmd_operand), 32'hFFF);
        drain();

        // Timeout: valid held exactly TOUT cycles, then the next command goes.
        cmd_ack = 1'b0;
        strobe(15'h3111);
        strobe(15'h2222);
        cnt = 0;
        while (cmd_valid && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("t5_valid_width", 32'(cnt), 32'(TOUT));
        chk("t5_timeout_err", 32'(timeout_err), 32'd1);
        tick();
        chk("t5_next_valid", 32'(cmd_valid), 32'd1);
        chk("t5_next_opcode", 32'(cmd_opcode), 32'd2);
        cmd_ack = 1'b1;
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t5_clr_ovf", 32'(overflow), 32'd0);
        chk("t5_clr_tout", 32'(timeout_err), 32'd0);
        chk("t5_clr_drops", 32'(drop_count), 32'd0);

        // enable low holds the queue; reset mid-ISSUE wipes everything.
        enable  = 1'b0;
        cmd_ack = 1'b0;
        for (int i = 0; i < 3; i++) strobe(15'(16'h4400 + 16'(i)));
        tick();
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_no_valid", 32'(cmd_valid), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd3);
        enable = 1'b1;
        tick();
        chk("t6_issue", 32'(cmd_valid), 32'd1);
        do_reset();
        chk("t6_rst_valid", 32'(cmd_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        cmd_ack = 1'b1;
        strobe(15'h4321);
        tick();
        chk("t6_after_rst", 32'(cmd_operand), 32'h321);
        drain();

        // Saturation of drop_count.
        enable = 1'b0;
        instruction_ready = 1'b1;
        for (int i = 0; i < 265; i++) begin
            instruction_in = 15'($urandom);
            tick();
        end
        instruction_ready = 1'b0;
        chk("sat_drops", 32'(drop_count), 32'd255);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            instruction_ready = ($urandom_range(0, 1) == 1);
            instruction_in    = ($urandom_range(0, 5) == 0) ? 15'($urandom_range(0, 4095))
                                                            : 15'($urandom);
            cmd_ack           = ($urandom_range(0, 2) == 0);
            enable            = ($urandom_range(0, 9) != 0);
            clear_err         = ($urandom_range(0, 19) == 0);
            tick();
        end
        instruction_ready = 1'b0;
        clear_err = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
